alu_pipe: RTL and testbench
===========================

# alu_pipe

Parametrised, two-stage pipelined successor to the combinational 8-bit ALU. It executes the same `enum_pkg::Opcode` operation set on `WIDTH`-bit operands and adds status flags. Operands and results move through valid/ready handshakes, so the block can sit between a register-file read stage and a writeback stage. It sustains one operation per cycle and supports back-pressure and synchronous flush.

## Interface
- `WIDTH`, default 8: operand/result width; legal range 4..64.
- `SHW`, default `$clog2(WIDTH)`: derived, not overridable; shift-amount width.

Ports:
- `clk` in 1: clock; all state updates on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `flush` in 1: synchronous; empties both pipeline stages.
- `in_valid` in 1: operand beat present.
- `in_ready` out 1: block accepts the beat this cycle.
- `a` in `WIDTH`: operand A.
- `b` in `WIDTH`: operand B; also the shift amount.
- `op` in `Opcode`: one of Add, Sub, And, Or, Xor, Leftshift, RightshiftLogic, RightshiftArith, Equal.
- `out_valid` out 1: result beat present.
- `out_ready` in 1: consumer accepts the result.
- `result` out `WIDTH`: operation result.
- `flag_c` out 1: carry (Add) or borrow (Sub).
- `flag_v` out 1: signed overflow (Add/Sub only).
- `flag_z` out 1: `result == 0`.
- `flag_n` out 1: `result[WIDTH-1]`.

## Operation
**Stage 1 (S1)**
- Registers `a`, `b` and `op`, and sets valid `s1_v`.

**Stage 2 (S2)**
- Computes from the S1 registers.
- Registers `result` and the flags, and sets `out_valid`.

**Advance rules**
- `s2_adv = !out_valid | out_ready`.
- `s1_adv = !s1_v | s2_adv`.
- `in_ready = s1_adv` (combinational).
- An input beat is accepted when `in_valid & in_ready`.

**Arithmetic** (all modulo 2^WIDTH)
- Add: `result = a + b`; `flag_c` = carry out of the MSB.
- Sub: `result = a - b`; `flag_c = (a < b)` unsigned (borrow).
- `flag_v` for Add and Sub is the signed two's-complement overflow.
- And, Or, Xor: bitwise.
- Leftshift: `a << b`.
- RightshiftLogic: `a >> b`, zero fill.
- RightshiftArith: `a >>> b`, MSB fill.
- Shift amounts: the full `b` is used. If `b >= WIDTH`, the logical shifts give 0 and the arithmetic shift gives all copies of `a[WIDTH-1]`.
- Equal: `result = {{WIDTH-1{1'b0}}, a == b}`.

**Flag rules**
- `flag_c` and `flag_v` are 0 for every op other than Add and Sub.
- `flag_z` and `flag_n` are computed for every op.
- An unlisted `op` encoding gives `result = 0`, with `flag_z = 1` and all other flags 0.

**Flush**
- On the next edge, clears `s1_v` and `out_valid`.
- Any beat accepted in the flush cycle is discarded.
- `in_ready` is independent of `flush`.

## Timing
**Reset values**
- `out_valid` = 0, `s1_v` = 0.
- `result` = 0, `flag_c` = 0, `flag_v` = 0, `flag_z` = 0, `flag_n` = 0.
- `in_ready` = 1 while the pipeline is empty.

**Latency and throughput**
- Latency is 2 cycles: a beat accepted at edge N appears with `out_valid` = 1 after edge N+1.
- Throughput is 1 beat/cycle when `out_ready` is held at 1.

**Back-pressure**
- While `out_valid & !out_ready`, `result` and the flags hold stable.
- With S1 also full, `in_ready` = 0.
- When `out_ready` is raised, both stages advance in the same cycle and `in_ready` returns to 1 combinationally.

**Boundary cases**
- Simultaneous output drain and input accept: no bubble is inserted.
- Reset mid-operation: in-flight beats are lost and all outputs return to their reset values immediately (asynchronously).
- Flush and reset asserted together: reset dominates.

## Configuration
- Macro: `ALU_PIPE_SAT_EN`.
- **Defined:** Add and Sub saturate unsigned.
  - Add overflow gives all ones.
  - Sub underflow gives 0.
  - `flag_c` still reports the raw carry or borrow.
  - `flag_z` and `flag_n` reflect the saturated result.
- **Undefined:** Add and Sub wrap modulo 2^WIDTH.
- All other ops are unaffected in both builds.

## Test plan
1. WIDTH=8, Add 10+5: `result` = 15, `flag_c` = 0, `flag_z` = 0, 2 cycles after accept. Sub 10-5: `result` = 5. Sub 5-10: `result` = 8'hFB, `flag_c` = 1, `flag_n` = 1.
2. Logic and shifts:
   - And 0x0F, 0xF0 gives 0x00 with `flag_z` = 1.
   - Or 0x0F, 0xF0 gives 0xFF.
   - Xor 0xAA, 0x55 gives 0xFF.
   - 10 << 2 gives 40.
   - 128 >> 1 logical gives 64.
   - 128 >>> 1 gives 192.
   - 0x80 >>> 9 gives 0xFF.
   - 0x80 >> 8 gives 0.
3. Equal and overflow:
   - 50 Equal 50 gives 1; 25 Equal 30 gives 0.
   - Add 0x7F+0x01 gives 0x80 with `flag_v` = 1.
   - Add 0xFF+0x01 gives 0x00 with `flag_c` = 1 and `flag_z` = 1 without the macro. With `ALU_PIPE_SAT_EN` it gives 0xFF with `flag_c` = 1.
4. Streaming and back-pressure:
   - 8 back-to-back beats with `out_ready` = 1 produce 8 results in 8 consecutive cycles, in order.
   - Hold `out_ready` = 0 for 5 cycles: `in_ready` drops after 2 accepts, `result` stays stable, and no beat is lost or duplicated.
5. Flush and reset:
   - Flush with both stages full: `out_valid` = 0 on the next cycle and no stale result appears.
   - Assert `rst_n` = 0 mid-stream: outputs go to 0 asynchronously, and the first post-reset beat emerges with latency 2.
6. WIDTH=32: Add 0xFFFF_FFFF+1 gives 0 with `flag_c` = 1. Leftshift of 1 by 31 gives 0x8000_0000 with `flag_n` = 1.

Source files
------------

// File: rtl/alu_pipe.sv
// ============================================================================
// alu_pipe : two-stage valid/ready pipelined ALU with C/V/Z/N status flags.
//            Optional macro ALU_PIPE_SAT_EN makes Add/Sub saturate unsigned.
// Revision  : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package enum_pkg;
  typedef enum logic [3:0] {
    Add             = 4'd0,
    Sub             = 4'd1,
    And             = 4'd2,
    Or              = 4'd3,
    Xor             = 4'd4,
    Leftshift       = 4'd5,
    RightshiftLogic = 4'd6,
    RightshiftArith = 4'd7,
    Equal           = 4'd8
  } Opcode;
endpackage

module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  enum_pkg::Opcode   op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  result,
  output logic              flag_c,
  output logic              flag_v,
  output logic              flag_z,
  output logic              flag_n
);

  localparam int SHW = $clog2(WIDTH);

  logic             r_s1_v;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  enum_pkg::Opcode  r_op;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_fc;
  logic             r_fv;
  logic             r_fz;
  logic             r_fn;

  logic             w_s2_adv;
  logic             w_s1_adv;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic             w_add_ovf;
  logic             w_sub_ovf;
  logic             w_shift_big;
  logic [SHW-1:0]   w_shamt;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;

  assign w_s2_adv = !r_out_valid || out_ready;
  assign w_s1_adv = !r_s1_v || w_s2_adv;
  assign in_ready = w_s1_adv;

  assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
  assign w_diff = {1'b0, r_a} - {1'b0, r_b};

  assign w_add_ovf = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[WIDTH-1]  != r_a[WIDTH-1]);
  assign w_sub_ovf = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_diff[WIDTH-1] != r_a[WIDTH-1]);

  // The whole of b is the shift amount; only when b < WIDTH do its low SHW bits suffice.
  assign w_shift_big = (65'(r_b) >= 65'(WIDTH));
  assign w_shamt     = r_b[SHW-1:0];

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (r_op)
      enum_pkg::Add: begin
        w_c = w_sum[WIDTH];
        w_v = w_add_ovf;
`ifdef ALU_PIPE_SAT_EN
        w_res = w_sum[WIDTH] ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];
`else
        w_res = w_sum[WIDTH-1:0];
`endif
      end
      enum_pkg::Sub: begin
        w_c = w_diff[WIDTH];
        w_v = w_sub_ovf;
`ifdef ALU_PIPE_SAT_EN
        w_res = w_diff[WIDTH] ? '0 : w_diff[WIDTH-1:0];
`else
        w_res = w_diff[WIDTH-1:0];
`endif
      end
      enum_pkg::And:             w_res = r_a & r_b;
      enum_pkg::Or:              w_res = r_a | r_b;
      enum_pkg::Xor:             w_res = r_a ^ r_b;
      enum_pkg::Leftshift:       w_res = w_shift_big ? '0 : (r_a << w_shamt);
      enum_pkg::RightshiftLogic: w_res = w_shift_big ? '0 : (r_a >> w_shamt);
      enum_pkg::RightshiftArith: w_res = w_shift_big ? {WIDTH{r_a[WIDTH-1]}}
                                                     : $unsigned($signed(r_a) >>> w_shamt);
      enum_pkg::Equal:           w_res = {{(WIDTH-1){1'b0}}, (r_a == r_b)};
      default:                   w_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_v      <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= enum_pkg::Add;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_fc        <= 1'b0;
      r_fv        <= 1'b0;
      r_fz        <= 1'b0;
      r_fn        <= 1'b0;
    end else if (flush) begin
      r_s1_v      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_s1_adv) begin
        r_s1_v <= in_valid;
        if (in_valid) begin
          r_a  <= a;
          r_b  <= b;
          r_op <= op;
        end
      end
      // Output registers only move when a result is actually handed over.
      if (w_s2_adv) begin
        r_out_valid <= r_s1_v;
        if (r_s1_v) begin
          r_result <= w_res;
          r_fc     <= w_c;
          r_fv     <= w_v;
          r_fz     <= (w_res == '0);
          r_fn     <= w_res[WIDTH-1];
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign flag_c    = r_fc;
  assign flag_v    = r_fv;
  assign flag_z    = r_fz;
  assign flag_n    = r_fn;

endmodule

`default_nettype wire

// File: tb/tb_alu_pipe.sv
// ============================================================================
// tb_alu_pipe : self-checking bench for alu_pipe (WIDTH=8 and WIDTH=32).
// Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_alu_pipe;
  localparam int W = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    a;
  logic [W-1:0]    b;
  enum_pkg::Opcode op;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    result;
  logic            flag_c, flag_v, flag_z, flag_n;

  logic            in_valid32;
  logic            in_ready32;
  logic [31:0]     a32, b32, result32;
  enum_pkg::Opcode op32;
  logic            out_valid32;
  logic            c32, v32, z32, n32;

  int checks = 0;
  int errors = 0;
  logic [W+3:0] exp_q[$];

  typedef struct { logic [3:0] op; logic [7:0] a, b, res; logic [3:0] f; } vec_t;
  typedef struct { logic [3:0] op; logic [31:0] a, b, res; logic [3:0] f; } vec32_t;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flag_c(flag_c), .flag_v(flag_v), .flag_z(flag_z), .flag_n(flag_n)
  );

  alu_pipe #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(1'b0),
    .in_valid(in_valid32), .in_ready(in_ready32),
    .a(a32), .b(b32), .op(op32),
    .out_valid(out_valid32), .out_ready(1'b1),
    .result(result32), .flag_c(c32), .flag_v(v32), .flag_z(z32), .flag_n(n32)
  );

  // Reference: signed/unsigned integer arithmetic, packed as {c, v, z, n, result}.
  function automatic logic [W+3:0] model(input logic [3:0] opc, input logic [W-1:0] x,
                                         input logic [W-1:0] y);
    int ux, uy, sx, sy, r, s, maxu, maxs;
    logic c, v;
    logic [W-1:0] res;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    maxu = (1 << W) - 1;
    maxs = (1 << (W - 1)) - 1;
    r = 0; s = 0; c = 1'b0; v = 1'b0;
    case (opc)
      4'd0: begin
        r = ux + uy; s = sx + sy;
        c = (r > maxu); v = (s > maxs) || (s < -maxs - 1);
`ifdef ALU_PIPE_SAT_EN
        if (c) r = maxu;
`endif
      end
      4'd1: begin
        r = ux - uy; s = sx - sy;
        c = (ux < uy); v = (s > maxs) || (s < -maxs - 1);
`ifdef ALU_PIPE_SAT_EN
        if (c) r = 0;
`endif
      end
      4'd2: r = ux & uy;
      4'd3: r = ux | uy;
      4'd4: r = ux ^ uy;
      4'd5: r = (uy >= W) ? 0 : (ux << uy);
      4'd6: r = (uy >= W) ? 0 : (ux >> uy);
      4'd7: r = (uy >= W) ? ((sx < 0) ? -1 : 0) : (sx >>> uy);
      4'd8: r = (ux == uy) ? 1 : 0;
      default: r = 0;
    endcase
    res = r[W-1:0];
    return {c, v, (res == '0), res[W-1], res};
  endfunction

  task automatic test_reset();
    #1;
    checks++;
    if ({out_valid, flag_c, flag_v, flag_z, flag_n, result} !== '0 || in_ready !== 1'b1)
      begin errors++; $display("FAIL reset_async: got ov=%b flags=%b res=%h rdy=%b, want all 0, rdy=1",
        out_valid, {flag_c, flag_v, flag_z, flag_n}, result, in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({out_valid, flag_c, flag_v, flag_z, flag_n, result} !== '0 || in_ready !== 1'b1 ||
        out_valid32 !== 1'b0 || result32 !== 32'h0)
      begin errors++; $display("FAIL reset_release: got ov=%b res=%h rdy=%b ov32=%b, want 0/00/1/0",
        out_valid, result, in_ready, out_valid32); end
  endtask

  task automatic test_directed();
    vec_t vecs[$];
    vecs.push_back('{4'd0, 8'd10,  8'd5,  8'd15,  4'b0000});
    vecs.push_back('{4'd1, 8'd10,  8'd5,  8'd5,   4'b0000});
    vecs.push_back('{4'd2, 8'h0F,  8'hF0, 8'h00,  4'b0010});
    vecs.push_back('{4'd3, 8'h0F,  8'hF0, 8'hFF,  4'b0001});
    vecs.push_back('{4'd4, 8'hAA,  8'h55, 8'hFF,  4'b0001});
    vecs.push_back('{4'd5, 8'd10,  8'd2,  8'd40,  4'b0000});
    vecs.push_back('{4'd6, 8'd128, 8'd1,  8'd64,  4'b0000});
    vecs.push_back('{4'd7, 8'd128, 8'd1,  8'd192, 4'b0001});
    vecs.push_back('{4'd7, 8'h80,  8'd9,  8'hFF,  4'b0001});
    vecs.push_back('{4'd6, 8'h80,  8'd8,  8'h00,  4'b0010});
    vecs.push_back('{4'd5, 8'h81,  8'hFF, 8'h00,  4'b0010});
    vecs.push_back('{4'd7, 8'h40,  8'hC8, 8'h00,  4'b0010});
    vecs.push_back('{4'd8, 8'd50,  8'd50, 8'd1,   4'b0000});
    vecs.push_back('{4'd8, 8'd25,  8'd30, 8'd0,   4'b0010});
    vecs.push_back('{4'd0, 8'h7F,  8'h01, 8'h80,  4'b0101});
    vecs.push_back('{4'd1, 8'h80,  8'h01, 8'h7F,  4'b0100});
    vecs.push_back('{4'd12, 8'd3,  8'd4,  8'h00,  4'b0010});
    vecs.push_back('{4'd15, 8'hFF, 8'hFF, 8'h00,  4'b0010});
`ifdef ALU_PIPE_SAT_EN
    vecs.push_back('{4'd1, 8'd5,   8'd10, 8'h00,  4'b1010});
    vecs.push_back('{4'd0, 8'hFF,  8'h01, 8'hFF,  4'b1001});
    vecs.push_back('{4'd0, 8'h80,  8'h80, 8'hFF,  4'b1101});
`else
    vecs.push_back('{4'd1, 8'd5,   8'd10, 8'hFB,  4'b1001});
    vecs.push_back('{4'd0, 8'hFF,  8'h01, 8'h00,  4'b1010});
    vecs.push_back('{4'd0, 8'h80,  8'h80, 8'h00,  4'b1110});
`endif
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      op = enum_pkg::Opcode'(vecs[i].op); a = vecs[i].a; b = vecs[i].b;
      in_valid = 1'b1; out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL dir_in_ready[%0d]: got %b want 1", i, in_ready); end
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL dir_early[%0d]: out_valid got %b want 0", i, out_valid); end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || result !== vecs[i].res || {flag_c, flag_v, flag_z, flag_n} !== vecs[i].f)
        begin errors++; $display("FAIL dir[%0d] op=%0d a=%h b=%h: got ov=%b res=%h cvzn=%b, want ov=1 res=%h cvzn=%b",
          i, vecs[i].op, vecs[i].a, vecs[i].b, out_valid, result, {flag_c, flag_v, flag_z, flag_n},
          vecs[i].res, vecs[i].f); end
    end
  endtask

  task automatic test_back_to_back();
    logic [W+3:0] expv[8];
    logic [3:0]   oc;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      checks++;
      if (cyc >= 2 && cyc < 10) begin
        if (out_valid !== 1'b1 || {flag_c, flag_v, flag_z, flag_n, result} !== expv[cyc-2])
          begin errors++; $display("FAIL b2b[%0d]: got ov=%b data=%h want ov=1 data=%h",
            cyc - 2, out_valid, {flag_c, flag_v, flag_z, flag_n, result}, expv[cyc-2]); end
      end else if (out_valid !== 1'b0) begin
        errors++; $display("FAIL b2b_idle[%0d]: out_valid got %b want 0", cyc, out_valid);
      end
      if (cyc < 8) begin
        oc = 4'($urandom_range(0, 8));
        op = enum_pkg::Opcode'(oc); a = 8'($urandom); b = 8'($urandom_range(0, 9));
        in_valid = 1'b1; out_ready = 1'b1;
        expv[cyc] = model(oc, a, b);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", cyc, in_ready); end
      end else begin
        in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] oc;
    exp_q.delete();
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk);
      if (cyc >= 2) begin
        checks++;
        if (out_valid !== 1'b1 || exp_q.size() == 0 || {flag_c, flag_v, flag_z, flag_n, result} !== exp_q[0])
          begin errors++; $display("FAIL bp_hold[%0d]: got ov=%b data=%h, want stable first beat",
            cyc, out_valid, {flag_c, flag_v, flag_z, flag_n, result}); end
      end
      oc = 4'($urandom_range(0, 8));
      op = enum_pkg::Opcode'(oc); a = 8'($urandom); b = 8'($urandom_range(0, 9));
      in_valid = 1'b1; out_ready = 1'b0;
      #1;
      checks++;
      if (in_ready !== (cyc < 2)) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b want %b", cyc, in_ready, (cyc < 2)); end
      if (in_valid && in_ready) exp_q.push_back(model(oc, a, b));
    end
    checks++;
    if (exp_q.size() != 2) begin errors++; $display("FAIL bp_accepts: got %0d want 2", exp_q.size()); end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full: in_ready got %b want 0", in_ready); end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release: in_ready got %b want 1", in_ready); end
    for (int cyc = 0; cyc < 4; cyc++) begin
      if (out_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0 || {flag_c, flag_v, flag_z, flag_n, result} !== exp_q[0])
          begin errors++; $display("FAIL bp_drain[%0d]: got %h, want next queued beat", cyc,
            {flag_c, flag_v, flag_z, flag_n, result}); end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      @(negedge clk);
      #1;
    end
    checks++;
    if (exp_q.size() != 0 || out_valid !== 1'b0)
      begin errors++; $display("FAIL bp_lost_or_dup: left=%0d ov=%b, want 0/0", exp_q.size(), out_valid); end
  endtask

  task automatic test_flush();
    @(negedge clk);
    op = enum_pkg::Add; a = 8'd1; b = 8'd1; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    a = 8'd2;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_prefill: out_valid got %b want 1", out_valid); end
    a = 8'd3; out_ready = 1'b1; flush = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready: got %b want 1", in_ready); end
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_stale[%0d]: out_valid got %b want 0", cyc, out_valid); end
    end
    op = enum_pkg::Xor; a = 8'h3C; b = 8'h0F; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || result !== 8'h33)
      begin errors++; $display("FAIL flush_recover: got ov=%b res=%h want 1/33", out_valid, result); end
  endtask

  task automatic test_reset_mid();
    logic [W+3:0] first;
    @(negedge clk);
    op = enum_pkg::Or; a = 8'h41; b = 8'h02; in_valid = 1'b1; out_ready = 1'b1;
    first = model(4'd3, a, b);
    @(negedge clk);
    a = 8'h11;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || {flag_c, flag_v, flag_z, flag_n, result} !== first)
      begin errors++; $display("FAIL rstmid_pre: got ov=%b data=%h want 1/%h", out_valid,
        {flag_c, flag_v, flag_z, flag_n, result}, first); end
    #2;
    rst_n = 1'b0; flush = 1'b1;
    #1;
    checks++;
    if ({out_valid, flag_c, flag_v, flag_z, flag_n, result} !== '0 || in_ready !== 1'b1)
      begin errors++; $display("FAIL rstmid_async: got ov=%b res=%h rdy=%b want 0/00/1", out_valid, result, in_ready); end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || result !== 8'h00)
      begin errors++; $display("FAIL rstmid_hold: got ov=%b res=%h want 0/00", out_valid, result); end
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    op = enum_pkg::Sub; a = 8'd20; b = 8'd7; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_early: out_valid got %b want 0", out_valid); end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || result !== 8'd13)
      begin errors++; $display("FAIL rstmid_post: got ov=%b res=%h want 1/0d", out_valid, result); end
  endtask

  task automatic test_width32();
    vec32_t vecs[$];
    vecs.push_back('{4'd5, 32'h1,         32'd31, 32'h8000_0000, 4'b0001});
    vecs.push_back('{4'd7, 32'h8000_0000, 32'd40, 32'hFFFF_FFFF, 4'b0001});
    vecs.push_back('{4'd6, 32'h8000_0000, 32'd32, 32'h0,         4'b0010});
`ifdef ALU_PIPE_SAT_EN
    vecs.push_back('{4'd0, 32'hFFFF_FFFF, 32'h1,  32'hFFFF_FFFF, 4'b1001});
    vecs.push_back('{4'd1, 32'h0,         32'h1,  32'h0,         4'b1010});
`else
    vecs.push_back('{4'd0, 32'hFFFF_FFFF, 32'h1,  32'h0,         4'b1010});
    vecs.push_back('{4'd1, 32'h0,         32'h1,  32'hFFFF_FFFF, 4'b1001});
`endif
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      op32 = enum_pkg::Opcode'(vecs[i].op); a32 = vecs[i].a; b32 = vecs[i].b; in_valid32 = 1'b1;
      @(negedge clk);
      in_valid32 = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid32 !== 1'b1 || result32 !== vecs[i].res || {c32, v32, z32, n32} !== vecs[i].f)
        begin errors++; $display("FAIL w32[%0d]: got ov=%b res=%h cvzn=%b want 1 %h %b", i,
          out_valid32, result32, {c32, v32, z32, n32}, vecs[i].res, vecs[i].f); end
    end
  endtask

  task automatic test_random(input int nbeats, input int rdy_pct);
    int sent = 0;
    int got = 0;
    int cyc = 0;
    logic held = 1'b0;
    logic [W+3:0] held_val = '0;
    logic [3:0] oc;
    exp_q.delete();
    while (got < nbeats && cyc < 20000) begin
      @(negedge clk);
      if (held) begin
        checks++;
        if (out_valid !== 1'b1 || {flag_c, flag_v, flag_z, flag_n, result} !== held_val)
          begin errors++; $display("FAIL rnd_stable@%0d: got ov=%b data=%h want 1/%h", cyc, out_valid,
            {flag_c, flag_v, flag_z, flag_n, result}, held_val); end
      end
      oc = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      op = enum_pkg::Opcode'(oc);
      a = 8'($urandom);
      b = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 10));
      in_valid = (sent < nbeats) && ($urandom_range(0, 99) < 75);
      out_ready = ($urandom_range(0, 99) < rdy_pct);
      #1;
      if (in_valid && in_ready) begin exp_q.push_back(model(oc, a, b)); sent++; end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0 || {flag_c, flag_v, flag_z, flag_n, result} !== exp_q[0])
          begin errors++; $display("FAIL rnd[%0d]: got %h want %h", got,
            {flag_c, flag_v, flag_z, flag_n, result}, (exp_q.size() != 0) ? exp_q[0] : '0); end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        got++;
      end
      held = out_valid && !out_ready;
      held_val = {flag_c, flag_v, flag_z, flag_n, result};
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (got != nbeats) begin errors++; $display("FAIL rnd_timeout: got %0d results want %0d", got, nbeats); end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; op = enum_pkg::Add;
    in_valid32 = 1'b0; a32 = '0; b32 = '0; op32 = enum_pkg::Add;
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_width32();
    test_random(400, 60);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
